// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
// Optional feature macro used by muldiv_unit: MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

    localparam int MD_XLEN  = 64;
    localparam int MD_CNT_W = 7;

    // Operation encodings; 5..7 are illegal and yield a zero result.
    typedef enum logic [2:0] {
        OP_MUL   = 3'd0,
        OP_SMULH = 3'd1,
        OP_UMULH = 3'd2,
        OP_SDIV  = 3'd3,
        OP_UDIV  = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Writes to the zero register are suppressed at the write port.
    localparam logic [4:0] XZR_IDX = 5'd31;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_SMULH) || (op == OP_UMULH);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_SDIV) || (op == OP_UDIV);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_SMULH) || (op == OP_SDIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, purely combinational.
// Multiply: conditionally add the shifted multiplicand, shift multiplicand left
// and multiplier right. Divide: shift {remainder, dividend} left one bit, trial
// subtract the divisor, and shift the resulting quotient bit in at the LSB.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic                i_is_div,
    input  logic [2*XLEN-1:0]   i_x,   // mul: shifted multiplicand; div: {rem, dividend/quotient}
    input  logic [XLEN-1:0]     i_y,   // mul: remaining multiplier; div: divisor
    input  logic [2*XLEN-1:0]   i_p,   // mul: partial product
    output logic [2*XLEN-1:0]   o_x,
    output logic [XLEN-1:0]     o_y,
    output logic [2*XLEN-1:0]   o_p
);

    logic [XLEN:0]   w_sh_rem;
    logic            w_fits;
    logic [XLEN-1:0] w_new_rem;

    // The shifted remainder is XLEN+1 bits; a set top bit means it already exceeds any divisor.
    assign w_sh_rem  = i_x[2*XLEN-1:XLEN-1];
    assign w_fits    = w_sh_rem[XLEN] | (w_sh_rem[XLEN-1:0] >= i_y);
    assign w_new_rem = w_fits ? (w_sh_rem[XLEN-1:0] - i_y) : w_sh_rem[XLEN-1:0];

    // Select the multiply or divide iteration.
    always_comb begin
        o_x = i_x;
        o_y = i_y;
        o_p = i_p;
        if (i_is_div) begin
            o_x = {w_new_rem, i_x[XLEN-2:0], w_fits};
        end else begin
            o_p = i_y[0] ? (i_p + i_x) : i_p;
            o_x = {i_x[2*XLEN-2:0], 1'b0};
            o_y = {1'b0, i_y[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 64-bit MUL/SMULH/UMULH/SDIV/UDIV unit feeding the
// register-file write port. One bit per cycle; start/done handshake.
// Handshake: start is sampled only in IDLE; once accepted, busy stays high until
// the single-cycle done pulse ends, and result/wa_out hold until the next accept.
// Optional feature: define MULDIV_EARLY_OUT_EN to let multiplies leave CALC as
// soon as the remaining multiplier is zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic [4:0]        wa_in,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   result,
    output logic [4:0]        wa_out,
    output logic              we_out
);

    state_t              r_state;
    logic [2:0]          r_op;
    logic [4:0]          r_wa;
    logic                r_neg;
    logic                r_dz;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*XLEN-1:0]   r_x;
    logic [XLEN-1:0]     r_y;
    logic [2*XLEN-1:0]   r_p;
    logic [XLEN-1:0]     r_result;

    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic                w_in_signed;
    logic [2*XLEN-1:0]   w_step_x;
    logic [XLEN-1:0]     w_step_y;
    logic [2*XLEN-1:0]   w_step_p;
    logic                w_early_exit;
    logic                w_early_at_accept;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quot_fix;
    logic [XLEN-1:0]     w_fix_result;

    // Two's-complement magnitudes; the most negative value keeps its pattern as 2^(XLEN-1).
    assign w_in_signed = is_signed_op(op);
    assign w_a_mag     = (w_in_signed && a[XLEN-1]) ? (~a + 1'b1) : a;
    assign w_b_mag     = (w_in_signed && b[XLEN-1]) ? (~b + 1'b1) : b;

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early_exit      = is_mul_op(r_op) && (r_y == '0);
    assign w_early_at_accept = is_mul_op(op) && (w_b_mag == '0);
`else
    assign w_early_exit      = 1'b0;
    assign w_early_at_accept = 1'b0;
`endif

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .i_is_div (is_div_op(r_op)),
        .i_x      (r_x),
        .i_y      (r_y),
        .i_p      (r_p),
        .o_x      (w_step_x),
        .o_y      (w_step_y),
        .o_p      (w_step_p)
    );

    // Sign correction of the magnitude result; r_neg is only ever set for SMULH/SDIV.
    assign w_prod_fix = r_neg ? (~r_p + 1'b1) : r_p;
    assign w_quot_fix = r_neg ? (~r_x[XLEN-1:0] + 1'b1) : r_x[XLEN-1:0];

    // Pick the architectural result for the latched op; divide-by-zero and illegal ops give 0.
    always_comb begin
        w_fix_result = '0;
        case (r_op)
            OP_MUL:   w_fix_result = w_prod_fix[XLEN-1:0];
            OP_SMULH: w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
            OP_UMULH: w_fix_result = r_p[2*XLEN-1:XLEN];
            OP_SDIV:  w_fix_result = r_dz ? '0 : w_quot_fix;
            OP_UDIV:  w_fix_result = r_dz ? '0 : r_x[XLEN-1:0];
            default:  w_fix_result = '0;
        endcase
    end

    // Control FSM plus operand/accumulator registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_wa     <= '0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_cnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_p      <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_wa    <= wa_in;
                        r_neg   <= w_in_signed && (a[XLEN-1] ^ b[XLEN-1]);
                        r_dz    <= (b == '0);
                        r_cnt   <= CNT_W'(XLEN);
                        r_x     <= {{XLEN{1'b0}}, w_a_mag};
                        r_y     <= w_b_mag;
                        r_p     <= '0;
                        r_state <= w_early_at_accept ? FIXUP : CALC;
                    end
                end
                CALC: begin
                    if (w_early_exit) begin
                        r_state <= FIXUP;
                    end else begin
                        r_x   <= w_step_x;
                        r_y   <= w_step_y;
                        r_p   <= w_step_p;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= FIXUP;
                        end
                    end
                end
                FIXUP: begin
                    r_result <= w_fix_result;
                    r_state  <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);
    assign result = r_result;
    assign wa_out = r_wa;
    assign we_out = done && (r_wa != XZR_IDX);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed tests for muldiv_unit with hand-computed expectations.
// Build with +define+MULDIV_EARLY_OUT_EN to exercise the early-out variant.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam int MAX_WAIT = 200;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  wa_in;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic [4:0]  wa_out;
    logic        we_out;

    int n_checks;
    int n_fail;

    muldiv_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .wa_in   (wa_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .wa_out  (wa_out),
        .we_out  (we_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected cycles from accept to the done cycle (done cycle counted as cycle N).
    function automatic int exp_lat(input bit is_mul, input logic [63:0] bmag);
        int msb;
        if (EARLY && is_mul) begin
            if (bmag == 64'd0) return 2;
            msb = 0;
            for (int i = 0; i < 64; i++) if (bmag[i]) msb = i;
            return msb + 4;
        end
        return 66;
    endfunction

    // driver: present one request and step past the accept edge.
    task automatic issue(input logic [2:0] t_op, input logic [63:0] t_a,
                         input logic [63:0] t_b, input logic [4:0] t_wa);
        start = 1'b1;
        op    = t_op;
        a     = t_a;
        b     = t_b;
        wa_in = t_wa;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // driver: wait (bounded) for done, counting cycles since accept and tracking busy.
    task automatic wait_done(output int cyc, output bit busy_ok);
        cyc     = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < MAX_WAIT) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 3'd0;
        a       = '0;
        b       = '0;
        wa_in   = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
        n_checks++; if (wa_out !== 5'd0) begin n_fail++; $display("FAIL reset_wa_out: got %0d expected 0", wa_out); end
        n_checks++; if (we_out !== 1'b0) begin n_fail++; $display("FAIL reset_we_out: got %b expected 0", we_out); end
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        int cyc;
        bit bok;
        issue(OP_MUL, 64'd7, 64'd6, 5'd3);
        wait_done(cyc, bok);
        n_checks++; if (cyc != exp_lat(1'b1, 64'd6)) begin n_fail++; $display("FAIL mul_latency: got %0d expected %0d", cyc, exp_lat(1'b1, 64'd6)); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mul_done: got %b expected 1", done); end
        n_checks++; if (result !== 64'd42) begin n_fail++; $display("FAIL mul_result: got %h expected %h", result, 64'd42); end
        n_checks++; if (wa_out !== 5'd3) begin n_fail++; $display("FAIL mul_wa_out: got %0d expected 3", wa_out); end
        n_checks++; if (we_out !== 1'b1) begin n_fail++; $display("FAIL mul_we_out: got %b expected 1", we_out); end
        n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL mul_busy_during: got %b expected 1", bok); end
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_after: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mul_done_pulse: got %b expected 0", done); end
        n_checks++; if (result !== 64'd42) begin n_fail++; $display("FAIL mul_result_hold: got %h expected %h", result, 64'd42); end

        issue(OP_MUL, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 5'd8);
        wait_done(cyc, bok);
        n_checks++; if (result !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL mul_wide_result: got %h expected %h", result, 64'hFFFF_FFFE_0000_0001); end
        n_checks++; if (cyc != exp_lat(1'b1, 64'h0000_0000_FFFF_FFFF)) begin n_fail++; $display("FAIL mul_wide_latency: got %0d expected %0d", cyc, exp_lat(1'b1, 64'h0000_0000_FFFF_FFFF)); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mulh();
        int cyc;
        bit bok;
        issue(OP_SMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4);
        wait_done(cyc, bok);
        n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL smulh_m1_result: got %h expected 0", result); end
        n_checks++; if (cyc != exp_lat(1'b1, 64'd1)) begin n_fail++; $display("FAIL smulh_m1_latency: got %0d expected %0d", cyc, exp_lat(1'b1, 64'd1)); end
        @(posedge clk);
        #1;
        issue(OP_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5);
        wait_done(cyc, bok);
        n_checks++; if (result !== 64'd1) begin n_fail++; $display("FAIL umulh_result: got %h expected 1", result); end
        n_checks++; if (cyc != exp_lat(1'b1, 64'd2)) begin n_fail++; $display("FAIL umulh_latency: got %0d expected %0d", cyc, exp_lat(1'b1, 64'd2)); end
        @(posedge clk);
        #1;
        // -3 * 5 = -15: the 128-bit product's high half is all ones.
        issue(OP_SMULH, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd6);
        wait_done(cyc, bok);
        n_checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL smulh_neg_result: got %h expected %h", result, 64'hFFFF_FFFF_FFFF_FFFF); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_div();
        int cyc;
        bit bok;
        issue(OP_SDIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd9);
        wait_done(cyc, bok);
        n_checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFF2) begin n_fail++; $display("FAIL sdiv_neg_result: got %h expected %h", result, 64'hFFFF_FFFF_FFFF_FFF2); end
        n_checks++; if (cyc != 66) begin n_fail++; $display("FAIL sdiv_latency: got %0d expected 66", cyc); end
        @(posedge clk);
        #1;
        issue(OP_SDIV, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd9);
        wait_done(cyc, bok);
        n_checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFF2) begin n_fail++; $display("FAIL sdiv_negdiv_result: got %h expected %h", result, 64'hFFFF_FFFF_FFFF_FFF2); end
        @(posedge clk);
        #1;
        issue(OP_UDIV, 64'd100, 64'd0, 5'd10);
        wait_done(cyc, bok);
        n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL udiv_zero_result: got %h expected 0", result); end
        n_checks++; if (cyc != 66) begin n_fail++; $display("FAIL udiv_zero_latency: got %0d expected 66", cyc); end
        @(posedge clk);
        #1;
        issue(OP_SDIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11);
        wait_done(cyc, bok);
        n_checks++; if (result !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL sdiv_min_result: got %h expected %h", result, 64'h8000_0000_0000_0000); end
        @(posedge clk);
        #1;
        issue(OP_UDIV, 64'd1000, 64'd33, 5'd12);
        wait_done(cyc, bok);
        n_checks++; if (result !== 64'd30) begin n_fail++; $display("FAIL udiv_result: got %h expected %h", result, 64'd30); end
        @(posedge clk);
        #1;
        issue(OP_UDIV, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 5'd12);
        wait_done(cyc, bok);
        n_checks++; if (result !== 64'd1) begin n_fail++; $display("FAIL udiv_big_result: got %h expected 1", result); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_xzr();
        int cyc;
        bit bok;
        issue(OP_MUL, 64'd3, 64'd3, 5'd31);
        wait_done(cyc, bok);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL xzr_done: got %b expected 1", done); end
        n_checks++; if (result !== 64'd9) begin n_fail++; $display("FAIL xzr_result: got %h expected 9", result); end
        n_checks++; if (we_out !== 1'b0) begin n_fail++; $display("FAIL xzr_we_out: got %b expected 0", we_out); end
        n_checks++; if (wa_out !== 5'd31) begin n_fail++; $display("FAIL xzr_wa_out: got %0d expected 31", wa_out); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_illegal();
        int cyc;
        bit bok;
        issue(3'd5, 64'd7, 64'd6, 5'd2);
        wait_done(cyc, bok);
        n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL illegal_result: got %h expected 0", result); end
        n_checks++; if (cyc != 66) begin n_fail++; $display("FAIL illegal_latency: got %0d expected 66", cyc); end
        n_checks++; if (we_out !== 1'b1) begin n_fail++; $display("FAIL illegal_we_out: got %b expected 1", we_out); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit bok;
        start = 1'b1;
        op    = OP_MUL;
        a     = 64'd11;
        b     = 64'd13;
        wa_in = 5'd4;
        @(posedge clk);
        #1;
        // Keep start asserted with new operands for the rest of the first operation.
        a     = 64'd2;
        b     = 64'd3;
        wa_in = 5'd6;
        wait_done(cyc, bok);
        n_checks++; if (result !== 64'd143) begin n_fail++; $display("FAIL b2b_first_result: got %h expected %h", result, 64'd143); end
        n_checks++; if (cyc != exp_lat(1'b1, 64'd13)) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected %0d", cyc, exp_lat(1'b1, 64'd13)); end
        n_checks++; if (wa_out !== 5'd4) begin n_fail++; $display("FAIL b2b_first_wa_out: got %0d expected 4", wa_out); end
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got %b expected 0", busy); end
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept: got %b expected 1", busy); end
        wait_done(cyc, bok);
        n_checks++; if (result !== 64'd6) begin n_fail++; $display("FAIL b2b_second_result: got %h expected 6", result); end
        n_checks++; if (wa_out !== 5'd6) begin n_fail++; $display("FAIL b2b_second_wa_out: got %0d expected 6", wa_out); end
        n_checks++; if (cyc != exp_lat(1'b1, 64'd3)) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected %0d", cyc, exp_lat(1'b1, 64'd3)); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit bok;
        issue(OP_UDIV, 64'd1000, 64'd3, 5'd7);
        repeat (29) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", done); end
        n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL rstmid_result: got %h expected 0", result); end
        n_checks++; if (wa_out !== 5'd0) begin n_fail++; $display("FAIL rstmid_wa_out: got %0d expected 0", wa_out); end
        n_checks++; if (we_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_we_out: got %b expected 0", we_out); end
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        issue(OP_UDIV, 64'd100, 64'd7, 5'd5);
        wait_done(cyc, bok);
        n_checks++; if (result !== 64'd14) begin n_fail++; $display("FAIL rstmid_after_result: got %h expected 14", result); end
        n_checks++; if (cyc != 66) begin n_fail++; $display("FAIL rstmid_after_latency: got %0d expected 66", cyc); end
        n_checks++; if (we_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_after_we_out: got %b expected 1", we_out); end
        @(posedge clk);
        #1;
    endtask

`ifdef MULDIV_EARLY_OUT_EN
    task automatic test_early_out();
        int cyc;
        bit bok;
        issue(OP_MUL, 64'd9, 64'd1, 5'd1);
        wait_done(cyc, bok);
        n_checks++; if (cyc != 4) begin n_fail++; $display("FAIL early_b1_latency: got %0d expected 4", cyc); end
        n_checks++; if (result !== 64'd9) begin n_fail++; $display("FAIL early_b1_result: got %h expected 9", result); end
        @(posedge clk);
        #1;
        issue(OP_MUL, 64'd5, 64'd0, 5'd1);
        wait_done(cyc, bok);
        n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL early_b0_latency: got %0d expected 2", cyc); end
        n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL early_b0_result: got %h expected 0", result); end
        @(posedge clk);
        #1;
    endtask
`endif

    // sequence of scenarios and final report
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_xzr();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
`ifdef MULDIV_EARLY_OUT_EN
        test_early_out();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
